arty_top: RTL and testbench

ARTY_TOP -- requirements
Module: arty_top

---
 rtl/arty_top.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_arty_top.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arty_top.sv
`timescale 1ns/1ps
// Arty bring-up top: clock lock indicator, a one-shot "Hello!\r\n" banner,
// then a single-byte UART echo with framing/overrun error reporting on led[0].
module arty_top #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 1562500,
    parameter int LOCK_CYCLES = 256
) (
    input  logic       xtal_in,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic [3:0] btn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [3:0] led
);

    localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int LOCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BANNER,
        ST_ECHO
    } state_t;

    function automatic logic [7:0] banner_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    banner_byte = 8'h48;
            3'd1:    banner_byte = 8'h65;
            3'd2:    banner_byte = 8'h6C;
            3'd3:    banner_byte = 8'h6C;
            3'd4:    banner_byte = 8'h6F;
            3'd5:    banner_byte = 8'h21;
            3'd6:    banner_byte = 8'h0D;
            default: banner_byte = 8'h0A;
        endcase
    endfunction

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic              sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic              rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic              rx_prev_q, rx_prev_d;
    state_t            state_q, state_d;
    logic [3:0]        ban_cnt_q, ban_cnt_d;
    logic              tx_busy_q, tx_busy_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0]  tx_cyc_q, tx_cyc_d;
    logic              rx_active_q, rx_active_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [CNT_W-1:0]  rx_cyc_q, rx_cyc_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              buf_full_q, buf_full_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              err_q, err_d;

    logic              core_rst;
    logic              tx_done, tx_free, tx_load, buf_take;
    logic [7:0]        tx_byte;
    logic              rx_sample, rx_valid, frame_err;
    logic              unused_inputs;

    assign unused_inputs = ^{sw[2:0], btn[2:0]};
    assign core_rst      = !locked_q || btn_sync_q;
    assign tx_done       = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cyc_q == BIT_LAST);
    assign tx_free       = !tx_busy_q || tx_done;
    assign rx_sample     = rx_active_q &&
                           (rx_cyc_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST));

    always_comb begin
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        btn_meta_d  = btn[3];
        btn_sync_d  = btn_meta_q;
        sw_meta_d   = sw[3];
        sw_sync_d   = sw_meta_q;
        rx_meta_d   = uart_rx;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        state_d     = state_q;
        ban_cnt_d   = ban_cnt_q;
        tx_busy_d   = tx_busy_q;
        tx_data_d   = tx_data_q;
        tx_bit_d    = tx_bit_q;
        tx_cyc_d    = tx_cyc_q;
        rx_active_d = rx_active_q;
        rx_bit_d    = rx_bit_q;
        rx_cyc_d    = rx_cyc_q;
        rx_shift_d  = rx_shift_q;
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
        err_d       = err_q;
        tx_load     = 1'b0;
        tx_byte     = 8'h00;
        buf_take    = 1'b0;
        rx_valid    = 1'b0;
        frame_err   = 1'b0;

        if (!locked_q) begin
            if (lock_cnt_q == LOCK_LAST) begin
                locked_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end

        if (tx_busy_q) begin
            if (tx_cyc_q == BIT_LAST) begin
                tx_cyc_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cyc_d = tx_cyc_q + 1'b1;
            end
        end

        // A new frame may launch in the final stop-bit cycle so banner bytes chain with no gap.
        case (state_q)
            ST_IDLE: begin
                if (sw_sync_q) begin
                    state_d   = ST_BANNER;
                    ban_cnt_d = 4'd0;
                end
            end
            ST_BANNER: begin
                if (ban_cnt_q < 4'd8 && tx_free) begin
                    tx_load   = 1'b1;
                    tx_byte   = banner_byte(ban_cnt_q[2:0]);
                    ban_cnt_d = ban_cnt_q + 4'd1;
                end else if (ban_cnt_q == 4'd8 && tx_done) begin
                    state_d = ST_ECHO;
                end
            end
            ST_ECHO: begin
                if (buf_full_q && tx_free) begin
                    tx_load  = 1'b1;
                    tx_byte  = buf_data_q;
                    buf_take = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load) begin
            tx_busy_d = 1'b1;
            tx_data_d = tx_byte;
            tx_bit_d  = 4'd0;
            tx_cyc_d  = '0;
        end

        // The first sample lands mid start bit; every later one is a full bit apart.
        if (!rx_active_q) begin
            if (rx_prev_q && !rx_sync_q) begin
                rx_active_d = 1'b1;
                rx_bit_d    = 4'd0;
                rx_cyc_d    = '0;
            end
        end else if (rx_sample) begin
            rx_cyc_d = '0;
            if (rx_bit_q == 4'd0) begin
                if (rx_sync_q) begin
                    rx_active_d = 1'b0;
                end else begin
                    rx_bit_d = 4'd1;
                end
            end else if (rx_bit_q == 4'd9) begin
                rx_active_d = 1'b0;
                rx_valid    = rx_sync_q;
                frame_err   = !rx_sync_q;
            end else begin
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end
        end else begin
            rx_cyc_d = rx_cyc_q + 1'b1;
        end

        if (rx_valid) begin
            if (!buf_full_q || buf_take) begin
                buf_full_d = 1'b1;
                buf_data_d = rx_shift_q;
            end else begin
                err_d = 1'b1;
            end
        end else if (buf_take) begin
            buf_full_d = 1'b0;
        end

        if (frame_err) begin
            err_d = 1'b1;
        end

        if (core_rst) begin
            state_d     = ST_IDLE;
            ban_cnt_d   = 4'd0;
            tx_busy_d   = 1'b0;
            tx_data_d   = 8'h00;
            tx_bit_d    = 4'd0;
            tx_cyc_d    = '0;
            rx_active_d = 1'b0;
            rx_bit_d    = 4'd0;
            rx_cyc_d    = '0;
            rx_shift_d  = 8'h00;
            buf_full_d  = 1'b0;
            buf_data_d  = 8'h00;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge xtal_in or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            sw_meta_q   <= 1'b0;
            sw_sync_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            ban_cnt_q   <= 4'd0;
            tx_busy_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_bit_q    <= 4'd0;
            tx_cyc_q    <= '0;
            rx_active_q <= 1'b0;
            rx_bit_q    <= 4'd0;
            rx_cyc_q    <= '0;
            rx_shift_q  <= 8'h00;
            buf_full_q  <= 1'b0;
            buf_data_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            ban_cnt_q   <= ban_cnt_d;
            tx_busy_q   <= tx_busy_d;
            tx_data_q   <= tx_data_d;
            tx_bit_q    <= tx_bit_d;
            tx_cyc_q    <= tx_cyc_d;
            rx_active_q <= rx_active_d;
            rx_bit_q    <= rx_bit_d;
            rx_cyc_q    <= rx_cyc_d;
            rx_shift_q  <= rx_shift_d;
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            err_q       <= err_d;
        end
    end

    // Bit 1..8 maps to data index 0..7 through 3-bit wraparound.
    always_comb begin
        uart_tx = 1'b1;
        if (tx_busy_q) begin
            if (tx_bit_q == 4'd0) begin
                uart_tx = 1'b0;
            end else if (tx_bit_q != 4'd9) begin
                uart_tx = tx_data_q[tx_bit_q[2:0] - 3'd1];
            end
        end
    end

    assign led = {locked_q, state_q == ST_ECHO, tx_busy_q, err_q};

endmodule

// File: tb/tb_arty_top.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for arty_top: a serial-line monitor decodes every
// transmitted frame and checks it against bytes the stimulus expects to see.
module tb_arty_top;

    localparam int BIT = 64;

    logic       xtal_in = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] btn;
    logic       uart_rx;
    logic       uart_tx;
    logic [3:0] led;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b1;
    logic [7:0] banner_bytes [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0D, 8'h0A};

    arty_top dut (
        .xtal_in(xtal_in),
        .rst_n  (rst_n),
        .sw     (sw),
        .btn    (btn),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .led    (led)
    );

    always #5 xtal_in = ~xtal_in;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one 8N1 frame on uart_rx, then returns the line to idle.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val);
        @(negedge xtal_in);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge xtal_in);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (BIT) @(negedge xtal_in);
        end
        uart_rx = stop_val;
        repeat (BIT) @(negedge xtal_in);
        uart_rx = 1'b1;
    endtask

    task automatic waitLed(input int idx, input logic val, input int budget,
                           input string name, output int cycles);
        cycles = 0;
        while (led[idx] !== val && cycles < budget) begin
            @(negedge xtal_in);
            cycles++;
        end
        checkOutput(name, 32'(led[idx]), 32'(val));
    endtask

    task automatic pushBanner();
        for (int i = 0; i < 8; i++) exp_q.push_back(banner_bytes[i]);
    endtask

    // Serial monitor: decode at bit centres, then pop the scoreboard.
    initial begin : monitor
        logic [7:0] data;
        logic       start_bit;
        logic       stop_bit;
        time        t_start;
        time        last_start;
        last_start = 0;
        forever begin
            @(negedge uart_tx);
            t_start = $time;
            repeat (BIT / 2) @(negedge xtal_in);
            start_bit = uart_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge xtal_in);
                data[i] = uart_tx;
            end
            repeat (BIT) @(negedge xtal_in);
            stop_bit = uart_tx;
            if (mon_en) begin
                checkOutput("tx_start_bit", 32'(start_bit), 32'd0);
                checkOutput("tx_stop_bit", 32'(stop_bit), 32'd1);
                if (last_start != 0 && (t_start - last_start) < 64'd100000)
                    checkOutput("tx_frame_spacing", 32'((t_start - last_start) >= 64'd6400), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL tx_unexpected_byte: got 0x%0h, expected no frame at %0t",
                             data, $time);
                end else begin
                    checkOutput("tx_byte", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            last_start = t_start;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int         n;
        logic [7:0] b;
        logic [7:0] b0, b1, b2;

        rst_n   = 1'b0;
        sw      = 4'h0;
        btn     = 4'h0;
        uart_rx = 1'b1;
        #100;
        checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset_led", 32'(led), 32'd0);
        #50;
        rst_n = 1'b1;

        waitLed(3, 1'b1, 1000, "lock_led3", n);
        checkOutput("lock_delay", 32'(n >= 255 && n <= 257), 32'd1);
        checkOutput("idle_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("idle_led_low", 32'(led[2:0]), 32'd0);

        while ($time < 10150) #1;
        checkOutput("sw_off_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("sw_off_not_echo", 32'(led[2]), 32'd0);

        // Banner; sw[3] is dropped mid-banner and must have no effect.
        pushBanner();
        sw[3] = 1'b1;
        n = 0;
        while (led[2] !== 1'b1 && n < 6000) begin
            @(negedge xtal_in);
            n++;
            if (n == 1000) sw[3] = 1'b0;
        end
        checkOutput("banner_to_echo", 32'(led[2]), 32'd1);
        checkOutput("banner_duration", 32'(n >= 5120 && n <= 5135), 32'd1);
        checkOutput("banner_all_sent", 32'(exp_q.size()), 32'd0);
        checkOutput("banner_tx_idle", 32'(led[1]), 32'd0);
        sw[3] = 1'b1;

        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            applyStimulus(b, 1'b1);
            waitLed(1, 1'b1, 96, "echo_started", n);
            waitLed(1, 1'b0, 800, "echo_done", n);
            checkOutput("echo_no_error", 32'(led[0]), 32'd0);
            checkOutput("echo_sent", 32'(exp_q.size()), 32'd0);
        end

        b = 8'($urandom_range(0, 255));
        applyStimulus(b, 1'b0);
        repeat (700) @(negedge xtal_in);
        checkOutput("frame_err_led0", 32'(led[0]), 32'd1);
        checkOutput("frame_err_no_tx", 32'(led[1]), 32'd0);
        checkOutput("frame_err_still_echo", 32'(led[2]), 32'd1);

        // Core reset via btn[3], then overrun during the repeated banner.
        btn[3] = 1'b1;
        repeat (8) @(negedge xtal_in);
        checkOutput("btn_led_low", 32'(led[2:0]), 32'd0);
        checkOutput("btn_led3_kept", 32'(led[3]), 32'd1);
        checkOutput("btn_uart_tx", 32'(uart_tx), 32'd1);
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        pushBanner();
        exp_q.push_back(b0);
        btn[3] = 1'b0;
        waitLed(1, 1'b1, 100, "rebanner_started", n);
        applyStimulus(b0, 1'b1);
        applyStimulus(b1, 1'b1);
        applyStimulus(b2, 1'b1);
        waitLed(2, 1'b1, 6000, "rebanner_to_echo", n);
        waitLed(1, 1'b1, 50, "overrun_echo_start", n);
        waitLed(1, 1'b0, 800, "overrun_echo_done", n);
        repeat (700) @(negedge xtal_in);
        checkOutput("overrun_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("overrun_led0", 32'(led[0]), 32'd1);

        // Asynchronous rst_n during a low banner bit.
        mon_en = 1'b0;
        btn[3] = 1'b1;
        repeat (5) @(negedge xtal_in);
        btn[3] = 1'b0;
        repeat (700) @(negedge xtal_in);
        n = 0;
        while (uart_tx !== 1'b0 && n < 700) begin
            @(negedge xtal_in);
            n++;
        end
        checkOutput("midbanner_tx_low", 32'(uart_tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("async_led", 32'(led), 32'd0);
        sw = 4'h0;
        repeat (10) @(negedge xtal_in);
        rst_n = 1'b1;
        waitLed(3, 1'b1, 1000, "relock_led3", n);
        repeat (700) @(negedge xtal_in);
        checkOutput("post_reset_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("post_reset_led", 32'(led), 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
